// File: rtl/uart_rx_async_pkg.sv
// Shared UART receive definitions: FSM state encoding, oversample ratio and parity helper.
package uart_rx_async_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Expected parity bit for a data word: even parity when odd == 0.
    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous rx line; presets to idle-high.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw line one stage deeper each clock.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    end

    // Synchroniser flops, reset to the idle line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_async.sv
// UART receive engine driven by a 16x baud strobe: start validation, 7/8-bit deserialisation,
// optional parity, stop check and a ready/overflow handshake towards the host.
module uart_rx_async
    import uart_rx_async_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MID_SAMPLE  = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic       rx_idle
);

    localparam logic [3:0] MID      = 4'(MID_SAMPLE);
    localparam logic [3:0] TICK_MAX = 4'(OVERSAMPLE - 1);

    logic       rx_s;
    logic       mid_s;
    logic [3:0] tick_inc_s;
    logic [2:0] last_bit_s;

    rx_state_e  state_d,     state_q;
    logic [3:0] tick_cnt_d,  tick_cnt_q;
    logic [2:0] bit_cnt_d,   bit_cnt_q;
    logic [7:0] shift_d,     shift_q;
    logic       cfg_bit8_d,  cfg_bit8_q;
    logic       cfg_par_d,   cfg_par_q;
    logic       cfg_odd_d,   cfg_odd_q;
    logic       par_bad_d,   par_bad_q;
    logic       stop_bit_d,  stop_bit_q;
    logic       done_d,      done_q;
    logic       idle_d,      idle_q;

    logic [7:0] rx_byte_d,     rx_byte_q;
    logic       rx_ready_d,    rx_ready_q;
    logic       parity_err_d,  parity_err_q;
    logic       framing_err_d, framing_err_q;
    logic       overflow_d,    overflow_q;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_s    (rx_s)
    );

    assign mid_s      = (tick_cnt_q == MID);
    assign tick_inc_s = (tick_cnt_q == TICK_MAX) ? 4'd0 : tick_cnt_q + 4'd1;
    assign last_bit_s = cfg_bit8_q ? 3'd7 : 3'd6;

    // Frame FSM next state; everything except done holds between baud ticks.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cfg_bit8_d = cfg_bit8_q;
        cfg_par_d  = cfg_par_q;
        cfg_odd_d  = cfg_odd_q;
        par_bad_d  = par_bad_q;
        stop_bit_d = stop_bit_q;
        done_d     = 1'b0;
        if (baud_clock) begin
            tick_cnt_d = tick_inc_s;
            case (state_q)
                ST_IDLE: begin
                    tick_cnt_d = 4'd0;
                    if (!rx_s) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (mid_s && rx_s) begin
                        state_d = ST_IDLE;
                    end else if (mid_s) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = 3'd0;
                        shift_d    = 8'd0;
                        par_bad_d  = 1'b0;
                        cfg_bit8_d = bit8;
                        cfg_par_d  = parity_en;
                        cfg_odd_d  = odd_n_even;
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_DATA: begin
                    if (mid_s) begin
                        shift_d[bit_cnt_q] = rx_s;
                        if (bit_cnt_q == last_bit_s) begin
                            state_d = cfg_par_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (mid_s) begin
                        par_bad_d = (rx_s != parity_of(shift_q, cfg_odd_q));
                        state_d   = ST_STOP;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    if (mid_s) begin
                        stop_bit_d = rx_s;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        idle_d = (state_d == ST_IDLE);
    end

    // Frame FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            cfg_bit8_q <= 1'b0;
            cfg_par_q  <= 1'b0;
            cfg_odd_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bit_q <= 1'b1;
            done_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            cfg_bit8_q <= cfg_bit8_d;
            cfg_par_q  <= cfg_par_d;
            cfg_odd_q  <= cfg_odd_d;
            par_bad_q  <= par_bad_d;
            stop_bit_q <= stop_bit_d;
            done_q     <= done_d;
            idle_q     <= idle_d;
        end
    end

    // Host-facing status: completion loads data/errors; a read in the same clk suppresses overflow.
    always_comb begin
        rx_byte_d     = rx_byte_q;
        rx_ready_d    = rx_ready_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        overflow_d    = overflow_q;
        if (done_q) begin
            rx_byte_d     = shift_q;
            parity_err_d  = cfg_par_q & par_bad_q;
            framing_err_d = ~stop_bit_q;
            rx_ready_d    = 1'b1;
            if (rx_ready_q && !read_rx_byte) begin
                overflow_d = 1'b1;
            end else if (rx_ready_q) begin
                overflow_d = 1'b0;
            end else begin
                overflow_d = overflow_q;
            end
        end else if (read_rx_byte && rx_ready_q) begin
            rx_ready_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            rx_ready_d = rx_ready_q;
        end
    end

    // Host-facing status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte_q     <= 8'd0;
            rx_ready_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            rx_byte_q     <= rx_byte_d;
            rx_ready_q    <= rx_ready_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overflow_q    <= overflow_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_ready    = rx_ready_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign overflow    = overflow_q;
    assign rx_idle     = idle_q;

endmodule

// File: tb/tb_uart_rx_async.sv
// Directed bench for uart_rx_async: baud strobe every clk, so one bit lasts 16 clk.
module tb_uart_rx_async;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       baud_clock;
    logic       rx;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       read_rx_byte;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;
    logic       rx_idle;

    int n_cmp  = 0;
    int n_fail = 0;
    logic ready_at11;
    logic ready_at12;

    always #5 clk = ~clk;

    uart_rx_async dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .baud_clock   (baud_clock),
        .rx           (rx),
        .bit8         (bit8),
        .parity_en    (parity_en),
        .odd_n_even   (odd_n_even),
        .read_rx_byte (read_rx_byte),
        .rx_byte      (rx_byte),
        .rx_ready     (rx_ready),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .overflow     (overflow),
        .rx_idle      (rx_idle)
    );

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame from a negedge; stop bit is 16 clk with rx_ready captured 11 and 12 clk in.
    task automatic send_frame(input logic [7:0] data, input int nbits, input logic has_par,
                              input logic par_bit, input logic stop_bit, input logic read_at_done);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = data[i];
            repeat (16) @(negedge clk);
        end
        if (has_par) begin
            rx = par_bit;
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        repeat (11) @(negedge clk);
        ready_at11 = rx_ready;
        read_rx_byte = read_at_done;
        @(negedge clk);
        read_rx_byte = 1'b0;
        ready_at12 = rx_ready;
        repeat (4) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic host_read();
        read_rx_byte = 1'b1;
        @(negedge clk);
        read_rx_byte = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte); end
        n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
        n_cmp++; if (framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_framing_err got=%b exp=0", framing_err); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_cmp++; if (rx_idle !== 1'b1) begin n_fail++; $display("FAIL reset_rx_idle got=%b exp=1", rx_idle); end
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_8n1();
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (ready_at11 !== 1'b0) begin n_fail++; $display("FAIL 8n1_ready_early got=%b exp=0", ready_at11); end
        n_cmp++; if (ready_at12 !== 1'b1) begin n_fail++; $display("FAIL 8n1_ready_latency got=%b exp=1", ready_at12); end
        n_cmp++; if (rx_byte !== 8'hA5) begin n_fail++; $display("FAIL 8n1_rx_byte got=%h exp=a5", rx_byte); end
        n_cmp++; if ({parity_err, framing_err, overflow} !== 3'b000) begin n_fail++; $display("FAIL 8n1_errors got=%b exp=000", {parity_err, framing_err, overflow}); end
        n_cmp++; if (rx_idle !== 1'b1) begin n_fail++; $display("FAIL 8n1_idle got=%b exp=1", rx_idle); end
        host_read();
        n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL 8n1_read_clears got=%b exp=0", rx_ready); end
        n_cmp++; if (rx_byte !== 8'hA5) begin n_fail++; $display("FAIL 8n1_byte_holds got=%h exp=a5", rx_byte); end
        idle(8);
    endtask

    task automatic test_7e1();
        bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (rx_byte !== 8'h35) begin n_fail++; $display("FAIL 7e1_rx_byte got=%h exp=35", rx_byte); end
        n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL 7e1_parity_ok got=%b exp=0", parity_err); end
        n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL 7e1_ready got=%b exp=1", rx_ready); end
        host_read();
        idle(8);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (rx_byte !== 8'h35) begin n_fail++; $display("FAIL 7e1_bad_rx_byte got=%h exp=35", rx_byte); end
        n_cmp++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL 7e1_parity_bad got=%b exp=1", parity_err); end
        host_read();
        idle(8);
        bit8 = 1'b1; odd_n_even = 1'b1;
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if ({rx_byte, parity_err} !== {8'hA5, 1'b0}) begin n_fail++; $display("FAIL 8o1_good got=%h/%b exp=a5/0", rx_byte, parity_err); end
        host_read();
        parity_en = 1'b0; odd_n_even = 1'b0;
        idle(8);
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (framing_err !== 1'b1) begin n_fail++; $display("FAIL framing_set got=%b exp=1", framing_err); end
        n_cmp++; if (rx_byte !== 8'h3C) begin n_fail++; $display("FAIL framing_rx_byte got=%h exp=3c", rx_byte); end
        host_read();
        idle(24);
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if ({rx_byte, framing_err, rx_ready} !== {8'h00, 1'b0, 1'b1}) begin n_fail++; $display("FAIL framing_recover got=%h/%b/%b exp=00/0/1", rx_byte, framing_err, rx_ready); end
        host_read();
        idle(8);
    endtask

    task automatic test_overflow();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        n_cmp++; if (rx_byte !== 8'h22) begin n_fail++; $display("FAIL ovf_rx_byte got=%h exp=22", rx_byte); end
        host_read();
        n_cmp++; if ({rx_ready, overflow} !== 2'b00) begin n_fail++; $display("FAIL ovf_read_clears got=%b exp=00", {rx_ready, overflow}); end
        host_read();
        n_cmp++; if ({rx_ready, overflow, rx_byte} !== {2'b00, 8'h22}) begin n_fail++; $display("FAIL read_when_empty got=%b/%h exp=00/22", {rx_ready, overflow}, rx_byte); end
        idle(8);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if ({rx_ready, overflow} !== 2'b10) begin n_fail++; $display("FAIL b2b_flags got=%b exp=10", {rx_ready, overflow}); end
        n_cmp++; if (rx_byte !== 8'h22) begin n_fail++; $display("FAIL b2b_rx_byte got=%h exp=22", rx_byte); end
        host_read();
        idle(8);
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        n_cmp++; if (rx_idle !== 1'b0) begin n_fail++; $display("FAIL glitch_start_seen got=%b exp=0", rx_idle); end
        repeat (20) @(negedge clk);
        n_cmp++; if ({rx_idle, rx_ready} !== 2'b10) begin n_fail++; $display("FAIL glitch_reject got=%b exp=10", {rx_idle, rx_ready}); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rx_byte, rx_ready, parity_err, framing_err, overflow, rx_idle} !== {8'h00, 5'b00001})
            begin n_fail++; $display("FAIL midreset_outputs got=%h/%b exp=00/00001", rx_byte, {rx_ready, parity_err, framing_err, overflow, rx_idle}); end
        rx = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        n_cmp++; if ({rx_byte, rx_ready, rx_idle} !== {8'h00, 2'b01}) begin n_fail++; $display("FAIL midreset_release got=%h/%b exp=00/01", rx_byte, {rx_ready, rx_idle}); end
    endtask

    initial begin
        reset_n = 1'b0; baud_clock = 1'b1; rx = 1'b1;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0; read_rx_byte = 1'b0;
        @(negedge clk);
        test_reset();
        test_8n1();
        test_7e1();
        test_framing();
        test_overflow();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
